pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain_if.sv | 25 ++
 rtl/pipe_chain.sv | 93 +++++++++
 tb/tb_pipe_chain.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_chain_if.sv
// Handshake bundle for pipe_chain: the upstream beat with its mask flag,
// and the downstream beat with its ready.
interface pipe_chain_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             mask_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Side that produces input beats and consumes output beats
  modport master (
    output in_valid, in_data, mask_en, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The pipeline itself
  modport slave (
    input  in_valid, in_data, mask_en, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: a STAGES-deep chain of valid/data registers with a
// combinational ready path, optional per-beat masking at accept time,
// a synchronous flush and a registered occupancy counter.
module pipe_chain #(
  parameter int               WIDTH  = 8,
  parameter int               STAGES = 3,
  parameter logic [WIDTH-1:0] MASK   = WIDTH'(64'h5555_5555_5555_5555)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipe_chain_if.slave                  bus,
  input  logic                         flush,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES:0]   adv;
  logic [STAGES-1:0] valid_reg;
  logic [WIDTH-1:0]  data_reg [STAGES];
  logic [WIDTH-1:0]  src_data [STAGES];
  logic              src_valid [STAGES];
  logic [OCC_W-1:0]  occ_reg;
  logic              accept;
  logic              deliver;

  // Ready ripples back from the output: a stage may advance if it is empty
  // or the stage after it is advancing.
  always_comb begin
    adv = '0;
    adv[STAGES] = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = !valid_reg[i] || adv[i + 1];
    end
  end

  assign bus.in_ready = adv[0] && !flush && rst_n;
  assign accept       = bus.in_valid && bus.in_ready;
  assign deliver      = valid_reg[STAGES-1] && bus.out_ready;

  // What each stage would load when it advances; the mask is applied here
  // so the decision travels with the beat.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign src_data[gi]  = bus.mask_en ? (bus.in_data & MASK) : bus.in_data;
        assign src_valid[gi] = accept;
      end else begin : g_body
        assign src_data[gi]  = data_reg[gi-1];
        assign src_valid[gi] = valid_reg[gi-1];
      end
    end
  endgenerate

  // Stage registers: valid bits honour flush; data only moves with a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush) begin
          valid_reg[i] <= 1'b0;
        end else if (adv[i]) begin
          valid_reg[i] <= src_valid[i];
        end
        if (adv[i] && src_valid[i]) begin
          data_reg[i] <= src_data[i];
        end
      end
    end
  end

  // Occupancy tracks accepts and deliveries; flush empties the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else if (flush) begin
      occ_reg <= '0;
    end else if (accept && !deliver) begin
      occ_reg <= occ_reg + OCC_W'(1);
    end else if (deliver && !accept) begin
      occ_reg <= occ_reg - OCC_W'(1);
    end
  end

  assign bus.out_valid = valid_reg[STAGES-1];
  assign bus.out_data  = data_reg[STAGES-1];
  assign occupancy     = occ_reg;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (WIDTH=8, STAGES=3, default MASK).
module tb_pipe_chain;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] occupancy;
  int         checks;
  int         errors;

  pipe_chain_if #(.WIDTH(8)) bus ();

  pipe_chain #(.WIDTH(8), .STAGES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .flush     (flush),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("check %s value=%0h ok", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic m);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.mask_en  = m;
  endtask

  initial begin
    logic [7:0] bp_beats [4];
    logic       bp_rdy [4];
    checks = 0;
    errors = 0;
    bp_beats[0] = 8'h11; bp_beats[1] = 8'h22; bp_beats[2] = 8'h33; bp_beats[3] = 8'h44;
    bp_rdy[0] = 1'b1; bp_rdy[1] = 1'b1; bp_rdy[2] = 1'b1; bp_rdy[3] = 1'b0;

    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'hFF, 1'b0);
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: three back-to-back beats, three cycles of latency
    drive(1'b1, 8'hFF, 1'b0);
    cyc();
    check("st_occ1", 64'(occupancy), 64'd1);
    check("st_empty1", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 8'h0F, 1'b0);
    cyc();
    check("st_empty2", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 8'hA3, 1'b0);
    cyc();
    check("st_occ3", 64'(occupancy), 64'd3);
    check("st_v0", 64'(bus.out_valid), 64'd1);
    check("st_d0", 64'(bus.out_data), 64'hFF);
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    check("st_d1", 64'(bus.out_data), 64'h0F);
    check("st_occ_pop", 64'(occupancy), 64'd2);
    cyc();
    check("st_d2", 64'(bus.out_data), 64'hA3);
    cyc();
    check("st_drained", 64'(bus.out_valid), 64'd0);
    check("st_occ0", 64'(occupancy), 64'd0);

    // Masking decided at accept time, mask_en toggled while in flight
    drive(1'b1, 8'hFF, 1'b1);
    cyc();
    drive(1'b1, 8'hFF, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b1);
    cyc();
    check("mk_d0", 64'(bus.out_data), 64'h55);
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    check("mk_d1", 64'(bus.out_data), 64'hFF);
    cyc();
    check("mk_drained", 64'(bus.out_valid), 64'd0);

    // Backpressure: only three of four beats fit
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bp_beats[i], 1'b0);
      #1;
      check($sformatf("bp_in_ready%0d", i), 64'(bus.in_ready), 64'(bp_rdy[i]));
      cyc();
    end
    check("bp_occ_full", 64'(occupancy), 64'd3);
    check("bp_hold_data", 64'(bus.out_data), 64'h11);

    // Full with simultaneous pop and push: 0x44 enters as 0x11 leaves
    bus.out_ready = 1'b1;
    #1;
    check("full_in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check("full_occ", 64'(occupancy), 64'd3);
    check("bp_d1", 64'(bus.out_data), 64'h22);
    drive(1'b0, 8'h00, 1'b0);
    cyc();
    check("bp_d2", 64'(bus.out_data), 64'h33);
    cyc();
    check("bp_d3", 64'(bus.out_data), 64'h44);
    check("bp_v3", 64'(bus.out_valid), 64'd1);
    cyc();
    check("bp_drained", 64'(bus.out_valid), 64'd0);
    check("bp_occ0", 64'(occupancy), 64'd0);

    // Flush with two beats in flight and a pending input
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hAA, 1'b0);
    cyc();
    drive(1'b1, 8'hBB, 1'b0);
    cyc();
    check("fl_occ2", 64'(occupancy), 64'd2);
    drive(1'b1, 8'hCC, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_in_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check("fl_occ0", 64'(occupancy), 64'd0);
    check("fl_out_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-cycle with the chain full
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h61 + i), 1'b0);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0);
    check("ar_occ3", 64'(occupancy), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(bus.out_valid), 64'd0);
    check("ar_occ0", 64'(occupancy), 64'd0);
    check("ar_out_data", 64'(bus.out_data), 64'h00);
    check("ar_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h5A, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    check("ar_lat1", 64'(bus.out_valid), 64'd0);
    cyc();
    check("ar_lat2", 64'(bus.out_valid), 64'd0);
    cyc();
    check("ar_lat3_v", 64'(bus.out_valid), 64'd1);
    check("ar_lat3_d", 64'(bus.out_data), 64'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
